// File: rtl/lampfpu_sqrt_iter.sv
// Iterative radix-2 restoring square root for a packed {sign, exp, frac} float, one root bit per cycle.
// Define LAMP_SQRT_SUBNORM_EN to normalise subnormal operands; otherwise they flush to signed zero.
module lampfpu_sqrt_iter #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [E_DW+F_DW:0] op_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               flush_i,
    output logic [E_DW+F_DW:0] res_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               invalid_o,
    output logic               inexact_o
);
    localparam int W      = 1 + E_DW + F_DW;
    localparam int E_BIAS = 2 ** (E_DW - 1) - 1;
    localparam int QW     = F_DW + 2;   // root bits: integer, fraction, guard
    localparam int RW     = 2 * QW;
    localparam int REMW   = QW + 3;
    localparam int XW     = E_DW + 2;   // signed unbiased exponent
    localparam int CW     = $clog2(QW);
    localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} stateT;

    stateT           stateQ, stateD;
    logic            readyQ, invalidQ, inexactQ;
    logic [W-1:0]    resQ;
    logic [W-2:0]    opQ;
    logic [CW-1:0]   cntQ;
    logic [RW-1:0]   radQ;
    logic [REMW-1:0] remQ;
    logic [QW-1:0]   rootQ;
    logic [E_DW-1:0] expQ;

    // Operand classification, evaluated on the accept cycle.
    logic            opSign;
    logic [E_DW-1:0] opExp;
    logic [F_DW-1:0] opFrac;
    logic            isSpecial, specInvalid;
    logic [W-1:0]    specRes;

    assign {opSign, opExp, opFrac} = op_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        isSpecial   = 1'b1;
        specRes     = QNAN;
        specInvalid = 1'b0;
        if (opExp == '1) begin
            if (opFrac != '0)
                specInvalid = ~opFrac[F_DW-1];
            else if (!opSign)
                specRes = op_i;
            else
                specInvalid = 1'b1;
        end else if (opExp == '0 && opFrac == '0) begin
            specRes = {opSign, {(W-1){1'b0}}};
        end else if (opExp == '0) begin
`ifdef LAMP_SQRT_SUBNORM_EN
            if (opSign)
                specInvalid = 1'b1;
            else
                isSpecial = 1'b0;
`else
            specRes = {opSign, {(W-1){1'b0}}};
`endif
        end else if (opSign) begin
            specInvalid = 1'b1;
        end else begin
            isSpecial = 1'b0;
        end
    end

    // Normalisation: unbias, make the exponent even, halve it.
    logic [E_DW-1:0]      nExp;
    logic [F_DW-1:0]      nFrac;
    logic [F_DW:0]        mantN;
    logic signed [XW-1:0] unbExp;
    logic [QW-1:0]        mantS;
    logic [E_DW-1:0]      expN;

    assign {nExp, nFrac} = opQ;

`ifdef LAMP_SQRT_SUBNORM_EN
    localparam int NW = $clog2(F_DW + 1) + 1;
    logic [F_DW:0]   mant0;
    logic [NW-1:0]   nlz;
    logic [XW-1:0]   effExp;

    always_comb begin
        mant0 = {nExp != '0, nFrac};
        nlz   = '0;
        for (int i = 0; i <= F_DW; i++)
            if (mant0[i]) nlz = NW'(F_DW - i);
        mantN  = mant0 << nlz;
        effExp = (nExp == '0) ? XW'(1) : XW'(nExp);
        unbExp = $signed(effExp - XW'(E_BIAS) - XW'(nlz));
    end
`else
    assign mantN  = {1'b1, nFrac};
    assign unbExp = $signed(XW'(nExp) - XW'(E_BIAS));
`endif

    // An arithmetic shift drops the odd bit, which is exactly the decrement after the mantissa doubles.
    assign mantS = unbExp[0] ? {mantN, 1'b0} : {1'b0, mantN};
    assign expN  = E_DW'($unsigned(unbExp >>> 1) + XW'(E_BIAS));

    // One restoring step: bring down two radicand bits, try subtracting 4q+1.
    logic [REMW-1:0] remShift, trial, remNext;
    logic            geq;

    always_comb begin
        remShift = {remQ[REMW-3:0], radQ[RW-1 -: 2]};
        trial    = {1'b0, rootQ, 2'b01};
        geq      = remShift >= trial;
        remNext  = geq ? remShift - trial : remShift;
    end

    // Rounding; the integer root bit is always 1, so a carry out of the fraction bumps the exponent.
    logic            guardBit, stickyBit, roundUp, carryR;
    logic [F_DW-1:0] fracR;

    always_comb begin
        guardBit        = rootQ[0];
        stickyBit       = |remQ;
        roundUp         = guardBit & (stickyBit | rootQ[1]);
        {carryR, fracR} = {1'b0, rootQ[F_DW:1]} + (F_DW+1)'(roundUp);
    end

    always_comb begin
        stateD = stateQ;
        if (flush_i) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE:    if (valid_i && readyQ) stateD = isSpecial ? DONE : NORM;
                NORM:    stateD = ITER;
                ITER:    if (cntQ == '0) stateD = ROUND;
                ROUND:   stateD = DONE;
                DONE:    if (ready_i) stateD = IDLE;
                default: stateD = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= IDLE;
            readyQ   <= 1'b0;
            resQ     <= '0;
            invalidQ <= 1'b0;
            inexactQ <= 1'b0;
            opQ      <= '0;
            cntQ     <= '0;
            radQ     <= '0;
            remQ     <= '0;
            rootQ    <= '0;
            expQ     <= '0;
        end else begin
            stateQ <= stateD;
            readyQ <= (stateD == IDLE);
            if (flush_i) begin
                invalidQ <= 1'b0;
                inexactQ <= 1'b0;
            end else begin
                case (stateQ)
                    IDLE: if (valid_i && readyQ) begin
                        opQ <= op_i[W-2:0];
                        if (isSpecial) begin
                            resQ     <= specRes;
                            invalidQ <= specInvalid;
                            inexactQ <= 1'b0;
                        end
                    end
                    NORM: begin
                        radQ  <= {mantS, {QW{1'b0}}};
                        remQ  <= '0;
                        rootQ <= '0;
                        expQ  <= expN;
                        cntQ  <= CW'(QW - 1);
                    end
                    ITER: begin
                        radQ  <= radQ << 2;
                        remQ  <= remNext;
                        rootQ <= {rootQ[QW-2:0], geq};
                        if (cntQ != '0) cntQ <= cntQ - CW'(1);
                    end
                    ROUND: begin
                        resQ     <= {1'b0, expQ + E_DW'(carryR), fracR};
                        invalidQ <= 1'b0;
                        inexactQ <= guardBit | stickyBit;
                    end
                    DONE: if (ready_i) begin
                        invalidQ <= 1'b0;
                        inexactQ <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready_o   = readyQ;
    assign valid_o   = (stateQ == DONE);
    assign res_o     = resQ;
    assign invalid_o = invalidQ;
    assign inexact_o = inexactQ;

endmodule

// File: tb/tb_lampfpu_sqrt_iter.sv
// Scoreboard bench for lampfpu_sqrt_iter (E_DW=8, F_DW=7) with hand-computed directed vectors.
module tb_lampfpu_sqrt_iter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] op_i = '0;
    logic         valid_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         ready_o, valid_o, invalid_o, inexact_o;
    logic [W-1:0] res_o;

    always #5 clk = ~clk;

    lampfpu_sqrt_iter #(.E_DW(8), .F_DW(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_i      (op_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .flush_i   (flush_i),
        .res_o     (res_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .invalid_o (invalid_o),
        .inexact_o (inexact_o)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         inv;
        logic         inx;
        int           lat;
        int           acc;
    } expT;

    expT  sb[$];
    int   cyc = 0;
    int   nTests = 0;
    int   nFail = 0;
    logic prevValid = 1'b0;
    logic expectReady = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: compares every cycle the DUT presents a result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            prevValid   = 1'b0;
            expectReady = 1'b0;
        end else begin
            if (expectReady) begin
                check("ready_after_handshake", 32'(ready_o), 32'd1);
                expectReady = 1'b0;
            end
            if (valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(valid_o), 32'd0);
                end else begin
                    if (!prevValid)
                        check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    check("res", 32'(res_o), 32'(sb[0].res));
                    check("invalid", 32'(invalid_o), 32'(sb[0].inv));
                    check("inexact", 32'(inexact_o), 32'(sb[0].inx));
                    check("ready_while_valid", 32'(ready_o), 32'd0);
                    if (ready_i) begin
                        void'(sb.pop_front());
                        expectReady = 1'b1;
                    end
                end
            end else begin
                check("flags_when_idle", 32'({invalid_o, inexact_o}), 32'd0);
            end
            prevValid = valid_o;
        end
    end

    task automatic send(input logic [W-1:0] op, input logic [W-1:0] res,
                        input logic inv, input logic inx, input int lat);
        int  waited = 0;
        expT e;
        @(posedge clk); #1;
        op_i    = op;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) begin
            check("accept_timeout", 32'(ready_o), 32'd1);
            valid_i = 1'b0;
            return;
        end
        e.res = res;
        e.inv = inv;
        e.inx = inx;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("ready_after_accept", 32'(ready_o), 32'd0);
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb.size() != 0 || !ready_o) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic runVec(input logic [W-1:0] op, input logic [W-1:0] res,
                          input logic inv, input logic inx, input int lat);
        send(op, res, inv, inx, lat);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   waited;
        logic sawValid;

        // Reset behaviour.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_res", 32'(res_o), 32'd0);
        check("rst_flags", 32'({invalid_o, inexact_o}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'd1);

        // Normal operands: 12-cycle latency.
        runVec(16'h4080, 16'h4000, 1'b0, 1'b0, 12);   // 4.0 -> 2.0
        runVec(16'h4000, 16'h3FB5, 1'b0, 1'b1, 12);   // 2.0 -> 1.414
        runVec(16'h4110, 16'h4040, 1'b0, 1'b0, 12);   // 9.0 -> 3.0
        runVec(16'h3F80, 16'h3F80, 1'b0, 1'b0, 12);   // 1.0 -> 1.0
        runVec(16'h3E80, 16'h3F00, 1'b0, 1'b0, 12);   // 0.25 -> 0.5
        runVec(16'h4040, 16'h3FDE, 1'b0, 1'b1, 12);   // 3.0 -> 1.732, rounds up
        runVec(16'h407F, 16'h3FFF, 1'b0, 1'b1, 12);   // largest mantissa, odd exponent
        runVec(16'h7F7F, 16'h5F7F, 1'b0, 1'b1, 12);   // largest normal
        runVec(16'h0080, 16'h2000, 1'b0, 1'b0, 12);   // smallest normal

        // Special operands: 1-cycle latency.
        runVec(16'hBF80, 16'h7FC0, 1'b1, 1'b0, 1);    // -1.0
        runVec(16'hC000, 16'h7FC0, 1'b1, 1'b0, 1);    // -2.0
        runVec(16'h7F80, 16'h7F80, 1'b0, 1'b0, 1);    // +inf
        runVec(16'hFF80, 16'h7FC0, 1'b1, 1'b0, 1);    // -inf
        runVec(16'h0000, 16'h0000, 1'b0, 1'b0, 1);    // +0
        runVec(16'h8000, 16'h8000, 1'b0, 1'b0, 1);    // -0
        runVec(16'h7FC0, 16'h7FC0, 1'b0, 1'b0, 1);    // qNaN
        runVec(16'hFFC1, 16'h7FC0, 1'b0, 1'b0, 1);    // negative qNaN with payload
        runVec(16'h7F81, 16'h7FC0, 1'b1, 1'b0, 1);    // sNaN

        // Subnormal operands.
`ifdef LAMP_SQRT_SUBNORM_EN
        runVec(16'h0001, 16'h1E35, 1'b0, 1'b1, 12);
        runVec(16'h807F, 16'h7FC0, 1'b1, 1'b0, 1);
`else
        runVec(16'h0001, 16'h0000, 1'b0, 1'b0, 1);
        runVec(16'h807F, 16'h8000, 1'b0, 1'b0, 1);
`endif

        // Result held while the consumer stalls for 3 cycles.
        ready_i = 1'b0;
        send(16'h4080, 16'h4000, 1'b0, 1'b0, 12);
        waited = 0;
        while (!valid_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("hold_valid_seen", 32'(valid_o), 32'd1);
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
        drain();

        // Flush in the 4th ITER cycle: the result never appears.
        @(posedge clk); #1;
        op_i    = 16'h4080;
        valid_i = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!ready_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("flush_op_accepted", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("ready_after_flush", 32'(ready_o), 32'd1);
        sawValid = 1'b0;
        repeat (16) begin
            @(negedge clk);
            sawValid = sawValid | valid_o;
        end
        check("flush_no_valid", 32'(sawValid), 32'd0);
        runVec(16'h4080, 16'h4000, 1'b0, 1'b0, 12);

        // Flush wins over valid_i in IDLE: nothing is accepted.
        @(posedge clk); #1;
        op_i    = 16'h7F80;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_blocks_accept", 32'(ready_o), 32'd1);
        check("flush_blocks_valid", 32'(valid_o), 32'd0);

        // Flush in DONE discards a held result.
        ready_i = 1'b0;
        send(16'h7F80, 16'h7F80, 1'b0, 1'b0, 1);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        ready_i = 1'b1;
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        check("done_flush_valid", 32'(valid_o), 32'd0);
        check("done_flush_ready", 32'(ready_o), 32'd1);
        runVec(16'h4000, 16'h3FB5, 1'b0, 1'b1, 12);

        drain();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
